uart_rx_frame: RTL

UART receive path. It is the counterpart of the UART_TX chain (serializer, parity_calc, TX FSM). It oversamples the serial line, detects the start bit, and recovers 8 data bits LSB-first. It then checks the optional parity bit and the stop bit, and delivers a parallel byte with a one-cycle valid pulse or an error flag. The block sits between the RX pad and the system-side consumer, such as a FIFO or register file.

---
 rtl/uart_rx_frame_if.sv | 33 +++
 rtl/uart_rx_frame.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_if.sv
// Signal bundle between the UART RX pad side and the receiver core.
// The master drives the serial line and frame configuration; the slave returns the recovered byte and status pulses.
interface uart_rx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN,
        output PAR_EN,
        output PAR_TYP,
        input  P_DATA,
        input  data_valid,
        input  par_err,
        input  stp_err
    );

    modport slave (
        input  RX_IN,
        input  PAR_EN,
        input  PAR_TYP,
        output P_DATA,
        output data_valid,
        output par_err,
        output stp_err
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: oversampled start detect, 3-sample majority vote per bit, LSB-first data,
// optional even/odd parity, stop-bit check, and one-cycle valid/error pulses.
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_frame_if.slave bus
);
    localparam int SYNC_STAGES = 2;
    localparam int ECW = $clog2(PRESCALE);
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [ECW-1:0] SAMP_A    = ECW'(PRESCALE / 2 - 1);
    localparam logic [ECW-1:0] SAMP_B    = ECW'(PRESCALE / 2);
    localparam logic [ECW-1:0] SAMP_C    = ECW'(PRESCALE / 2 + 1);
    localparam logic [ECW-1:0] EDGE_LAST = ECW'(PRESCALE - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_q,      state_d;
    logic [SYNC_STAGES-1:0]  sync_q,       sync_d;
    logic [ECW-1:0]          edge_cnt_q,   edge_cnt_d;
    logic [BCW-1:0]          bit_cnt_q,    bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q,      shift_d;
    logic [1:0]              samp_q,       samp_d;
    logic                    bit_val_q,    bit_val_d;
    logic                    par_en_q,     par_en_d;
    logic                    par_typ_q,    par_typ_d;
    logic                    par_bad_q,    par_bad_d;
    logic                    armed_q,      armed_d;
    logic [DATA_WIDTH-1:0]   p_data_q,     p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_q,    par_err_d;
    logic                    stp_err_q,    stp_err_d;

    logic rx_s;
    logic vote;
    logic exp_par;
    logic at_samp_a;
    logic at_samp_b;
    logic at_samp_c;
    logic at_end;

    // RX_IN is asynchronous to clk; stage 0 takes the pad, later stages follow the chain.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_in
            assign sync_d[gi] = bus.RX_IN;
        end else begin : g_chain
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign at_samp_a = (edge_cnt_q == SAMP_A);
    assign at_samp_b = (edge_cnt_q == SAMP_B);
    assign at_samp_c = (edge_cnt_q == SAMP_C);
    assign at_end    = (edge_cnt_q == EDGE_LAST);

    // Third sample is the live rx_s, so the vote is ready on the last sample cycle itself.
    assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign exp_par = par_typ_q ? ~^shift_q : ^shift_q;

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        bit_val_d    = bit_val_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        armed_d      = armed_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q != IDLE) begin
            edge_cnt_d = at_end ? '0 : edge_cnt_q + 1'b1;
            if (at_samp_a) begin
                samp_d[0] = rx_s;
            end
            if (at_samp_b) begin
                samp_d[1] = rx_s;
            end
            if (at_samp_c) begin
                bit_val_d = vote;
            end
        end

        unique case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                // A start is only accepted once the line has been seen high, so a held
                // break after a stop error cannot masquerade as a stream of 0x00 frames.
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d    = START;
                    edge_cnt_d = ECW'(1);
                    bit_cnt_d  = '0;
                    par_en_d   = bus.PAR_EN;
                    par_typ_d  = bus.PAR_TYP;
                    par_bad_d  = 1'b0;
                    armed_d    = 1'b0;
                end
            end
            START: begin
                if (at_samp_c && vote) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    armed_d    = 1'b1;
                end else if (at_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_samp_c) begin
                    shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                end
                if (at_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (at_samp_c) begin
                    par_bad_d = (vote != exp_par);
                end
                if (at_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_end) begin
                    state_d = IDLE;
                    armed_d = bit_val_q;
                    if (!bit_val_q) begin
                        stp_err_d = 1'b1;
                        par_err_d = par_bad_q;
                    end else if (par_bad_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sync_q       <= '1;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            samp_q       <= '0;
            bit_val_q    <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            armed_q      <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            bit_val_q    <= bit_val_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            armed_q      <= armed_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;

    a_valid_excl_err: assert property (@(posedge clk) disable iff (!rst)
        !(data_valid_q && (par_err_q || stp_err_q)));
    a_valid_one_cycle: assert property (@(posedge clk) disable iff (!rst)
        data_valid_q |=> !data_valid_q);
    a_stp_one_cycle: assert property (@(posedge clk) disable iff (!rst)
        stp_err_q |=> !stp_err_q);
endmodule
